// File: rtl/core_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : core_wb_arbiter_if
// Description : Bundle of core-side write-back and memory-side signals shared
//               by the write-back arbiter and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface core_wb_arbiter_if #(
    parameter int CORE_NUM    = 16,
    parameter int BUS_TO_CORE = 32,
    parameter int LEN_W       = 4,
    parameter int ID_W        = $clog2(CORE_NUM)
);
    logic [CORE_NUM-1:0]             core_req;
    logic [CORE_NUM*LEN_W-1:0]       core_len;
    logic [CORE_NUM*BUS_TO_CORE-1:0] core_data;
    logic [CORE_NUM-1:0]             core_grant;
    logic [CORE_NUM-1:0]             core_beat_ack;
    logic                            mem_valid;
    logic                            mem_ready;
    logic [BUS_TO_CORE-1:0]          mem_data;
    logic [ID_W-1:0]                 mem_core_id;
    logic                            mem_last;
    logic                            busy;

    // Arbiter side
    modport master (
        input  core_req, core_len, core_data, mem_ready,
        output core_grant, core_beat_ack, mem_valid, mem_data,
               mem_core_id, mem_last, busy
    );

    // Cores + memory side
    modport slave (
        output core_req, core_len, core_data, mem_ready,
        input  core_grant, core_beat_ack, mem_valid, mem_data,
               mem_core_id, mem_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/core_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : core_wb_arbiter
// Description : Round-robin arbiter moving atomic per-core result bursts onto
//               the single write-back port to data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module core_wb_arbiter #(
    parameter int CORE_NUM    = 16,
    parameter int BUS_TO_CORE = 32,
    parameter int LEN_W       = 4,
    parameter int ID_W        = $clog2(CORE_NUM)
) (
    input  wire logic        clk,
    input  wire logic        reset,
    core_wb_arbiter_if.master bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic [CORE_NUM-1:0] c_one      = {{(CORE_NUM-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0]     c_last_rst = ID_W'(CORE_NUM-1);

    state_t                 state_q, state_d;
    logic [CORE_NUM-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [ID_W-1:0]        last_id_q, last_id_d;
    logic [LEN_W-1:0]       beats_left_q, beats_left_d;

    logic [ID_W-1:0]        idx;
    logic [ID_W-1:0]        winner;
    logic                   found;
    logic [LEN_W-1:0]       winner_len;
    logic [BUS_TO_CORE-1:0] sel_data;
    logic                   accept;

    // Scan from farthest to nearest so the nearest requester after last_id wins.
    always_comb begin
        idx    = '0;
        winner = '0;
        found  = 1'b0;
        for (int i = CORE_NUM; i >= 1; i--) begin
            idx = ID_W'((int'(last_id_q) + i) % CORE_NUM);
            if (bus.core_req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        winner_len = '0;
        sel_data   = '0;
        for (int k = 0; k < CORE_NUM; k++) begin
            if (winner == ID_W'(k)) winner_len = bus.core_len[k*LEN_W +: LEN_W];
            if (id_q == ID_W'(k))   sel_data   = bus.core_data[k*BUS_TO_CORE +: BUS_TO_CORE];
        end
    end

    assign accept = (state_q == XFER) && bus.mem_ready;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        id_d         = id_q;
        last_id_d    = last_id_q;
        beats_left_d = beats_left_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = XFER;
                    grant_d      = c_one << winner;
                    id_d         = winner;
                    beats_left_d = winner_len;
                end
            end
            XFER: begin
                // Requests and lengths are not looked at here: bursts are atomic.
                if (accept) begin
                    if (beats_left_q == '0) begin
                        state_d   = IDLE;
                        grant_d   = '0;
                        last_id_d = id_q;
                    end else begin
                        beats_left_d = beats_left_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            id_q         <= '0;
            last_id_q    <= c_last_rst;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            id_q         <= id_d;
            last_id_q    <= last_id_d;
            beats_left_q <= beats_left_d;
        end
    end

    assign bus.core_grant    = grant_q;
    assign bus.mem_valid     = (state_q == XFER);
    assign bus.busy          = (state_q == XFER);
    assign bus.mem_core_id   = id_q;
    assign bus.mem_data      = sel_data;
    assign bus.mem_last      = (state_q == XFER) && (beats_left_q == '0);
    assign bus.core_beat_ack = accept ? (c_one << id_q) : '0;

endmodule
`default_nettype wire

// File: tb/tb_core_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_wb_arbiter
// Description : Directed bench for core_wb_arbiter with a beat scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_wb_arbiter;

    localparam int CORE_NUM = 16;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic clk;
    logic reset;

    core_wb_arbiter_if bus ();

    core_wb_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    beat_t       exp_q[$];
    int          beat_idx[CORE_NUM];
    logic [15:0] acked = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int k, input int b);
        return 32'hD000_0000 | (32'(k) << 8) | 32'(b);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic push_beat(input int k, input int b, input logic last);
        beat_t e;
        e.id   = 4'(k);
        e.data = pat(k, b);
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic push_burst(input int k, input int len);
        for (int b = 0; b <= len; b++) push_beat(k, b, (b == len));
    endtask

    task automatic set_len(input int k, input int v);
        bus.core_len[k*4 +: 4] = 4'(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Core model: an idle core presents beat 0, each ack advances to the next beat.
    initial begin
        for (int k = 0; k < CORE_NUM; k++) begin
            beat_idx[k] = 0;
            bus.core_data[k*32 +: 32] = pat(k, 0);
        end
        forever begin
            step();
            for (int k = 0; k < CORE_NUM; k++) begin
                if (!bus.core_grant[k]) beat_idx[k] = 0;
                else if (acked[k])      beat_idx[k] = beat_idx[k] + 1;
                bus.core_data[k*32 +: 32] = pat(k, beat_idx[k]);
            end
            acked = '0;
        end
    end

    // Scoreboard monitor
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_valid && bus.mem_ready) begin
                acked = bus.core_beat_ack;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected: got beat from core %0d, required none", bus.mem_core_id);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_id",   32'(bus.mem_core_id), 32'(e.id));
                    chk("sb_data", bus.mem_data, e.data);
                    chk("sb_last", 32'(bus.mem_last), 32'(e.last));
                    chk("sb_ack",  32'(bus.core_beat_ack), 32'(16'h1 << e.id));
                end
            end else begin
                chk("idle_ack", 32'(bus.core_beat_ack), 32'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.core_req  = '0;
        bus.core_len  = '0;
        bus.mem_ready = 1'b1;

        // Reset and single request
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(bus.core_grant), 32'h0);
        chk("rst_valid", 32'(bus.mem_valid), 32'h0);
        chk("rst_busy",  32'(bus.busy), 32'h0);
        chk("rst_last",  32'(bus.mem_last), 32'h0);
        chk("rst_id",    32'(bus.mem_core_id), 32'h0);
        step();
        reset = 1'b0;
        bus.core_req = 16'h0004;
        set_len(2, 3);
        push_burst(2, 3);
        step();
        bus.core_req = '0;
        @(negedge clk);
        chk("t1_grant", 32'(bus.core_grant), 32'h0004);
        chk("t1_busy",  32'(bus.busy), 32'h1);
        chk("t1_id",    32'(bus.mem_core_id), 32'h2);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t1_busy_fall", 32'(bus.busy), 32'h0);

        // Round-robin fairness from a fresh reset
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.core_len = '0;
        bus.core_req = 16'hffff;
        for (int n = 0; n <= 16; n++) push_burst(n % 16, 0);
        for (int n = 0; n <= 16; n++) begin
            @(negedge clk);
            chk("rr_gap", 32'(bus.busy), 32'h0);
            @(negedge clk);
            chk("rr_grant", 32'(bus.core_grant), 32'(16'h1 << (n % 16)));
        end
        step();
        bus.core_req = '0;

        // Wrap: core 14 wins, then 15, 0, 1
        step();
        bus.core_req = 16'h4000;
        push_burst(14, 0);
        step();
        bus.core_req = '0;
        @(negedge clk);
        chk("wrap_g14", 32'(bus.core_grant), 32'h4000);
        step();
        bus.core_req = 16'h8003;
        push_burst(15, 0);
        push_burst(0, 0);
        push_burst(1, 0);
        step();
        bus.core_req = 16'h0003;
        @(negedge clk);
        chk("wrap_g15", 32'(bus.core_grant), 32'h8000);
        step();
        step();
        bus.core_req = 16'h0002;
        @(negedge clk);
        chk("wrap_g0", 32'(bus.core_grant), 32'h0001);
        step();
        step();
        bus.core_req = '0;
        @(negedge clk);
        chk("wrap_g1", 32'(bus.core_grant), 32'h0002);

        // Backpressure: ready 1,0,0,1,1 over a 3-beat burst
        step();
        bus.core_req = 16'h0020;
        set_len(5, 2);
        push_burst(5, 2);
        step();
        bus.core_req = '0;
        @(negedge clk);
        chk("bp_grant", 32'(bus.core_grant), 32'h0020);
        step();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("bp_data_s1", bus.mem_data, pat(5, 1));
        chk("bp_last_s1", 32'(bus.mem_last), 32'h0);
        step();
        @(negedge clk);
        chk("bp_data_s2", bus.mem_data, pat(5, 1));
        chk("bp_id_s2",   32'(bus.mem_core_id), 32'h5);
        step();
        bus.mem_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_last", 32'(bus.mem_last), 32'h1);
        step();
        @(negedge clk);
        chk("bp_done", 32'(bus.busy), 32'h0);

        // Atomicity and maximum length; core 4 waits behind core 3
        step();
        bus.core_req = 16'h0018;
        set_len(3, 15);
        set_len(4, 0);
        push_burst(3, 15);
        push_burst(4, 0);
        step();
        @(negedge clk);
        chk("at_grant3", 32'(bus.core_grant), 32'h0008);
        step();
        step();
        bus.core_req = 16'h0010;
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk("at_gap", 32'(bus.busy), 32'h0);
        @(negedge clk);
        chk("at_grant4", 32'(bus.core_grant), 32'h0010);
        step();
        bus.core_req = '0;

        // Reset on beat 2 of a 4-beat burst
        step();
        bus.core_req = 16'h0040;
        set_len(6, 3);
        push_beat(6, 0, 1'b0);
        push_beat(6, 1, 1'b0);
        step();
        bus.core_req = '0;
        @(negedge clk);
        chk("mr_grant", 32'(bus.core_grant), 32'h0040);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.core_len = '0;
        bus.core_req = 16'hffff;
        push_burst(0, 0);
        @(negedge clk);
        chk("mr_grant0", 32'(bus.core_grant), 32'h0);
        chk("mr_valid",  32'(bus.mem_valid), 32'h0);
        chk("mr_busy",   32'(bus.busy), 32'h0);
        chk("mr_last",   32'(bus.mem_last), 32'h0);
        chk("mr_id",     32'(bus.mem_core_id), 32'h0);
        step();
        bus.core_req = '0;
        @(negedge clk);
        chk("mr_first", 32'(bus.core_grant), 32'h0001);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("end_busy", 32'(bus.busy), 32'h0);
        chk("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
